// File: rtl/fp_div_iter_if.sv
// Request/result bundle for the iterative binary32 divider.
// The requester drives operands and the handshake. The divider returns
// unrounded fields in the exact form the rounding stage consumes.
interface fp_div_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm_i;
    logic [1:0]  fmt_i;
    logic        out_valid;
    logic        sig;
    logic [10:0] expo;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [1:0]  rema;
    logic [2:0]  rm;
    logic [1:0]  fmt;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        infs;
    logic        zero;

    modport master (
        output in_valid, flush, a, b, rm_i, fmt_i,
        input  in_ready, out_valid, sig, expo, mant, grs, rema, rm, fmt,
        input  snan, qnan, dbz, infs, zero
    );

    modport slave (
        input  in_valid, flush, a, b, rm_i, fmt_i,
        output in_ready, out_valid, sig, expo, mant, grs, rema, rm, fmt,
        output snan, qnan, dbz, infs, zero
    );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider using radix-2 restoring division, one quotient
// bit per cycle. It produces an unrounded sign, exponent, mantissa,
// guard/round/sticky bits and remainder status for the rounding stage.
// Special operands bypass the datapath and go straight to the result state.
module fp_div_iter (
    input  logic           clock,
    input  logic           reset,   // asynchronous, active low
    fp_div_iter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Count leading zeros of a 24-bit significand.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Architectural state and output registers.
    state_t      state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        sig_q;
    logic [10:0] expo_q;
    logic [24:0] mant_q;
    logic [2:0]  grs_q;
    logic [1:0]  rema_q;
    logic [2:0]  rm_q;
    logic [1:0]  fmt_q;
    logic [4:0]  flags_q;   // {snan, qnan, dbz, infs, zero}

    // Working registers for the operation in flight.
    logic        op_sig_q;
    logic [2:0]  op_rm_q;
    logic [1:0]  op_fmt_q;
    logic [25:0] rem_q;
    logic [23:0] mb_q;
    logic [25:0] quo_q;
    logic [4:0]  cnt_q;
    logic [11:0] exp_q;     // two's complement
    logic [10:0] res_expo_q;
    logic [24:0] res_mant_q;
    logic [2:0]  res_grs_q;
    logic [1:0]  res_rema_q;
    logic [4:0]  res_flags_q;

    // Operand classification and unpacking.
    logic        a_zero_s, a_inf_s, a_nan_s, a_snan_s, a_qnan_s, a_sub_s;
    logic        b_zero_s, b_inf_s, b_nan_s, b_snan_s, b_qnan_s, b_sub_s;
    logic        special_s;
    logic [4:0]  spec_flags_s;
    logic [4:0]  lz_a_s, lz_b_s;
    logic [23:0] ma_s, mb_s;
    logic [11:0] ea_s, eb_s;
    logic [11:0] e_raw_s;
    logic [11:0] e_init_s;
    logic [24:0] ma_adj_s;

    // Division step.
    logic [26:0] trial_s;
    logic        q_bit_s;
    logic [25:0] sel_s;
    logic [25:0] rem_step_s;

    // Final normalization / denormalization.
    logic        e_ge1_s;
    logic [11:0] diff_s;
    logic [4:0]  norm_sh_s;
    logic [26:0] vec_s;
    logic [26:0] shifted_s;
    logic [26:0] mask_s;
    logic        lost_s;
    logic [10:0] norm_expo_s;
    logic [24:0] norm_mant_s;
    logic [2:0]  norm_grs_s;

    // Classify both operands and choose the special-case flag by priority.
    always_comb begin
        a_zero_s = (bus.a[30:23] == 8'd0)   && (bus.a[22:0] == 23'd0);
        a_sub_s  = (bus.a[30:23] == 8'd0)   && (bus.a[22:0] != 23'd0);
        a_inf_s  = (bus.a[30:23] == 8'hFF)  && (bus.a[22:0] == 23'd0);
        a_nan_s  = (bus.a[30:23] == 8'hFF)  && (bus.a[22:0] != 23'd0);
        a_snan_s = a_nan_s && !bus.a[22];
        a_qnan_s = a_nan_s &&  bus.a[22];
        b_zero_s = (bus.b[30:23] == 8'd0)   && (bus.b[22:0] == 23'd0);
        b_sub_s  = (bus.b[30:23] == 8'd0)   && (bus.b[22:0] != 23'd0);
        b_inf_s  = (bus.b[30:23] == 8'hFF)  && (bus.b[22:0] == 23'd0);
        b_nan_s  = (bus.b[30:23] == 8'hFF)  && (bus.b[22:0] != 23'd0);
        b_snan_s = b_nan_s && !bus.b[22];
        b_qnan_s = b_nan_s &&  bus.b[22];

        spec_flags_s = 5'b00000;
        special_s    = 1'b1;
        if (a_snan_s || b_snan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_flags_s = 5'b10000;
        end else if (a_qnan_s || b_qnan_s) begin
            spec_flags_s = 5'b01000;
        end else if (b_zero_s && !a_inf_s) begin
            spec_flags_s = 5'b00100;          // finite nonzero / 0
        end else if (a_inf_s) begin
            spec_flags_s = 5'b00010;          // inf / finite
        end else if (a_zero_s || b_inf_s) begin
            spec_flags_s = 5'b00001;          // 0 / x or finite / inf
        end else begin
            special_s    = 1'b0;
        end
    end

    // Unpack significands and normalize subnormals with a leading-zero shift.
    always_comb begin
        lz_a_s = lzc24({1'b0, bus.a[22:0]});
        lz_b_s = lzc24({1'b0, bus.b[22:0]});
        if (a_sub_s) begin
            ma_s = {1'b0, bus.a[22:0]} << lz_a_s;
            ea_s = 12'd1 - {7'd0, lz_a_s};
        end else begin
            ma_s = {1'b1, bus.a[22:0]};
            ea_s = {4'd0, bus.a[30:23]};
        end
        if (b_sub_s) begin
            mb_s = {1'b0, bus.b[22:0]} << lz_b_s;
            eb_s = 12'd1 - {7'd0, lz_b_s};
        end else begin
            mb_s = {1'b1, bus.b[22:0]};
            eb_s = {4'd0, bus.b[30:23]};
        end
        e_raw_s = ea_s - eb_s + 12'd127;
        // Pre-scale the dividend so the quotient lands in [1,2).
        if (ma_s < mb_s) begin
            ma_adj_s = {ma_s, 1'b0};
            e_init_s = e_raw_s - 12'd1;
        end else begin
            ma_adj_s = {1'b0, ma_s};
            e_init_s = e_raw_s;
        end
    end

    // One restoring-division step: subtract, keep the result if non-negative.
    always_comb begin
        trial_s    = {1'b0, rem_q} - {3'd0, mb_q};
        q_bit_s    = ~trial_s[26];
        if (q_bit_s) begin
            sel_s = trial_s[25:0];
        end else begin
            sel_s = rem_q;
        end
        rem_step_s = sel_s << 1;
    end

    // Pack the quotient. Underflowing results are shifted right into the
    // subnormal range, and every bit shifted out is folded into sticky.
    always_comb begin
        e_ge1_s = ($signed(exp_q) >= 12'sd1);
        diff_s  = 12'd1 - exp_q;
        if (e_ge1_s) begin
            norm_sh_s = 5'd0;
        end else if (diff_s > 12'd27) begin
            norm_sh_s = 5'd27;
        end else begin
            norm_sh_s = diff_s[4:0];
        end
        vec_s       = {quo_q, 1'b0};
        shifted_s   = vec_s >> norm_sh_s;
        mask_s      = (27'd1 << norm_sh_s) - 27'd1;
        lost_s      = |(vec_s & mask_s);
        norm_mant_s = {1'b0, shifted_s[26:3]};
        norm_grs_s  = {shifted_s[2], shifted_s[1], shifted_s[0] | lost_s};
        if (e_ge1_s) begin
            norm_expo_s = exp_q[10:0];
        end else begin
            norm_expo_s = 11'd0;
        end
    end

    // Control FSM plus the datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sig_q       <= 1'b0;
            expo_q      <= 11'd0;
            mant_q      <= 25'd0;
            grs_q       <= 3'd0;
            rema_q      <= 2'd0;
            rm_q        <= 3'd0;
            fmt_q       <= 2'd0;
            flags_q     <= 5'd0;
            op_sig_q    <= 1'b0;
            op_rm_q     <= 3'd0;
            op_fmt_q    <= 2'd0;
            rem_q       <= 26'd0;
            mb_q        <= 24'd0;
            quo_q       <= 26'd0;
            cnt_q       <= 5'd0;
            exp_q       <= 12'd0;
            res_expo_q  <= 11'd0;
            res_mant_q  <= 25'd0;
            res_grs_q   <= 3'd0;
            res_rema_q  <= 2'd0;
            res_flags_q <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && !bus.flush) begin
                        op_sig_q   <= bus.a[31] ^ bus.b[31];
                        op_rm_q    <= bus.rm_i;
                        op_fmt_q   <= bus.fmt_i;
                        in_ready_q <= 1'b0;
                        if (special_s) begin
                            res_expo_q  <= 11'd0;
                            res_mant_q  <= 25'd0;
                            res_grs_q   <= 3'd0;
                            res_rema_q  <= 2'd0;
                            res_flags_q <= spec_flags_s;
                            state_q     <= S_DONE;
                        end else begin
                            rem_q   <= {1'b0, ma_adj_s};
                            mb_q    <= mb_s;
                            exp_q   <= e_init_s;
                            quo_q   <= 26'd0;
                            cnt_q   <= 5'd0;
                            state_q <= S_DIV;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        rem_q <= rem_step_s;
                        quo_q <= {quo_q[24:0], q_bit_s};
                        if (cnt_q == 5'd25) begin
                            state_q <= S_NORM;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_NORM: begin
                    if (bus.flush) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        res_expo_q  <= norm_expo_s;
                        res_mant_q  <= norm_mant_s;
                        res_grs_q   <= norm_grs_s;
                        res_rema_q  <= {1'b0, (rem_q != 26'd0)};
                        res_flags_q <= 5'd0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First cycle publishes the result; second cycle is the pulse.
                    if (bus.flush) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                    end else if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        sig_q       <= op_sig_q;
                        rm_q        <= op_rm_q;
                        fmt_q       <= op_fmt_q;
                        expo_q      <= res_expo_q;
                        mant_q      <= res_mant_q;
                        grs_q       <= res_grs_q;
                        rema_q      <= res_rema_q;
                        flags_q     <= res_flags_q;
                    end else begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sig       = sig_q;
    assign bus.expo      = expo_q;
    assign bus.mant      = mant_q;
    assign bus.grs       = grs_q;
    assign bus.rema      = rema_q;
    assign bus.rm        = rm_q;
    assign bus.fmt       = fmt_q;
    assign bus.snan      = flags_q[4];
    assign bus.qnan      = flags_q[3];
    assign bus.dbz       = flags_q[2];
    assign bus.infs      = flags_q[1];
    assign bus.zero      = flags_q[0];

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter with hand-computed expected results.
module tb_fp_div_iter;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    fp_div_iter_if bus ();

    fp_div_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Issue one request, wait for the pulse and check every result field.
    task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [2:0] rmv, input logic [1:0] fmtv, input int lat,
                         input logic sg, input logic [10:0] ex, input logic [24:0] mn,
                         input logic [2:0] gr, input logic [1:0] re, input logic [4:0] fl);
        int n;
        @(negedge clock);
        chk({tag, ".ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.rm_i     = rmv;
        bus.fmt_i    = fmtv;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!bus.out_valid && n < 40);
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".sig"},  {31'd0, bus.sig},  {31'd0, sg});
        chk({tag, ".expo"}, {21'd0, bus.expo}, {21'd0, ex});
        chk({tag, ".mant"}, {7'd0, bus.mant},  {7'd0, mn});
        chk({tag, ".grs"},  {29'd0, bus.grs},  {29'd0, gr});
        chk({tag, ".rema"}, {30'd0, bus.rema}, {30'd0, re});
        chk({tag, ".flags"}, {27'd0, bus.snan, bus.qnan, bus.dbz, bus.infs, bus.zero}, {27'd0, fl});
        chk({tag, ".rmfmt"}, {27'd0, bus.rm, bus.fmt}, {27'd0, rmv, fmtv});
        chk({tag, ".busy_in_pulse"}, {31'd0, bus.in_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk({tag, ".pulse_end"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        int seen;
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.rm_i     = 3'd0;
        bus.fmt_i    = 2'd0;
        #12;
        chk("rst.ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.expo",  {21'd0, bus.expo}, 32'd0);
        chk("rst.mant",  {7'd0, bus.mant}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Normal path.
        do_op("one_div_one", 32'h3F800000, 32'h3F800000, 3'd0, 2'd0, 28,
              1'b0, 11'd127, 25'h0800000, 3'b000, 2'b00, 5'b00000);
        do_op("one_third",   32'h3F800000, 32'h40400000, 3'd2, 2'd1, 28,
              1'b0, 11'd125, 25'h0AAAAAA, 3'b100, 2'b01, 5'b00000);
        do_op("neg_three",   32'h40C00000, 32'hC0000000, 3'd3, 2'd0, 28,
              1'b1, 11'd128, 25'h0C00000, 3'b000, 2'b00, 5'b00000);
        do_op("sub_result",  32'h00800000, 32'h40000000, 3'd0, 2'd0, 28,
              1'b0, 11'd0,   25'h0400000, 3'b000, 2'b00, 5'b00000);
        do_op("min_sub_a",   32'h00000001, 32'h3F800000, 3'd0, 2'd0, 28,
              1'b0, 11'd0,   25'h0000001, 3'b000, 2'b00, 5'b00000);
        do_op("guard_only",  32'h00000001, 32'h40000000, 3'd0, 2'd0, 28,
              1'b0, 11'd0,   25'h0000000, 3'b100, 2'b00, 5'b00000);
        do_op("sticky_only", 32'h00000001, 32'h7F000000, 3'd0, 2'd0, 28,
              1'b0, 11'd0,   25'h0000000, 3'b001, 2'b00, 5'b00000);
        do_op("overflow",    32'h7F000000, 32'h00000001, 3'd4, 2'd0, 28,
              1'b0, 11'd403, 25'h0800000, 3'b000, 2'b00, 5'b00000);

        // Special cases.
        do_op("zero_zero",   32'h00000000, 32'h00000000, 3'd0, 2'd0, 1,
              1'b0, 11'd0, 25'd0, 3'b000, 2'b00, 5'b10000);
        do_op("snan_qnan",   32'h7F800001, 32'h7FC00000, 3'd0, 2'd0, 1,
              1'b0, 11'd0, 25'd0, 3'b000, 2'b00, 5'b10000);
        do_op("qnan",        32'h7FC00000, 32'h3F800000, 3'd0, 2'd0, 1,
              1'b0, 11'd0, 25'd0, 3'b000, 2'b00, 5'b01000);
        do_op("neg_dbz",     32'hBF800000, 32'h00000000, 3'd1, 2'd0, 1,
              1'b1, 11'd0, 25'd0, 3'b000, 2'b00, 5'b00100);
        do_op("inf_fin",     32'h7F800000, 32'h3F800000, 3'd0, 2'd0, 1,
              1'b0, 11'd0, 25'd0, 3'b000, 2'b00, 5'b00010);
        do_op("fin_inf",     32'h3F800000, 32'hFF800000, 3'd0, 2'd0, 1,
              1'b1, 11'd0, 25'd0, 3'b000, 2'b00, 5'b00001);
        do_op("pre_flush",   32'h3F800000, 32'h40400000, 3'd0, 2'd0, 28,
              1'b0, 11'd125, 25'h0AAAAAA, 3'b100, 2'b01, 5'b00000);

        // Flush while idle blocks a simultaneous request.
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.a        = 32'h3F800000;
        bus.b        = 32'h3F800000;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("idle_flush.ready", {31'd0, bus.in_ready}, 32'd1);

        // Flush in the middle of a division.
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.a        = 32'h40C00000;
        bus.b        = 32'hC0000000;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        chk("flush.ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clock);
            #1;
        end
        chk("flush.no_pulse", seen, 32'd0);
        chk("flush.held_expo", {21'd0, bus.expo}, 32'd125);
        chk("flush.held_sig", {31'd0, bus.sig}, 32'd0);
        do_op("after_flush", 32'h3F800000, 32'h3F800000, 3'd0, 2'd0, 28,
              1'b0, 11'd127, 25'h0800000, 3'b000, 2'b00, 5'b00000);

        // Asynchronous reset in the middle of a division.
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.a        = 32'h3F800000;
        bus.b        = 32'h40400000;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst.expo",  {21'd0, bus.expo}, 32'd0);
        chk("arst.mant",  {7'd0, bus.mant}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("arst.ready_after", {31'd0, bus.in_ready}, 32'd1);
        do_op("after_reset", 32'h40C00000, 32'hC0000000, 3'd5, 2'd2, 28,
              1'b1, 11'd128, 25'h0C00000, 3'b000, 2'b00, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
